// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths and the
// data-memory handshake state encoding.
package mem_stage_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int IMM8_WIDTH_DEF = 8;
    localparam int REG_WIDTH_DEF  = 4;
    localparam int TIMEOUT_DEF    = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory handshake controller: IDLE -> WAIT (request held) -> RESP,
// with a bounded wait counter and a sticky timeout error flag.
module mem_handshake_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_op_i,
    input  logic       ack_i,
    output logic       req_o,
    output logic       stall_o,
    output logic       capture_o,
    output logic       timeout_o,
    output logic       err_o,
    output logic [1:0] state_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_o     = 1'b0;
        stall_o   = 1'b0;
        capture_o = 1'b0;
        timeout_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mem_op_i) begin
                    stall_o = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_o   = 1'b1;
                stall_o = 1'b1;
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (ack_i) begin
                    capture_o = 1'b1;
                    state_d   = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    capture_o = 1'b1;
                    timeout_o = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign err_o   = err_q;
    assign state_o = state_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch/jump resolution, data-memory access with stall,
// forwarding value for EX, and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int IMM8_WIDTH = IMM8_WIDTH_DEF,
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic [IMM8_WIDTH-1:0] imm8M_i,
    input  logic [REG_WIDTH-1:0]  WriteRegM_i,
    input  logic [DATA_WIDTH-1:0] alu_outM_i,
    input  logic                  RegWriteM_i,
    input  logic                  BranchM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic                  MemToRegM_i,
    input  logic                  MovM_i,
    input  logic                  jumpM_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  stall_mem_o,
    output logic                  pc_src_o,
    output logic [ADDR_WIDTH-1:0] pc_target_o,
    output logic                  flush_o,
    output logic [DATA_WIDTH-1:0] WBResultM_o,
    output logic                  RegWriteW_o,
    output logic                  MemToRegW_o,
    output logic [REG_WIDTH-1:0]  WriteRegW_o,
    output logic [DATA_WIDTH-1:0] ReadDataW_o,
    output logic [DATA_WIDTH-1:0] ResultAW_o,
    output logic                  dmem_err_o
);

    logic       fsm_capture, fsm_timeout;
    logic [1:0] fsm_state;

    mem_handshake_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .mem_op_i  (MemReadM_i | MemWriteM_i),
        .ack_i     (dmem_ack_i),
        .req_o     (dmem_req_o),
        .stall_o   (stall_mem_o),
        .capture_o (fsm_capture),
        .timeout_o (fsm_timeout),
        .err_o     (dmem_err_o),
        .state_o   (fsm_state)
    );

    assign dmem_we_o    = dmem_req_o & MemWriteM_i;
    assign dmem_addr_o  = alu_outM_i[ADDR_WIDTH-1:0];
    assign dmem_wdata_o = WriteDataM_i;
    assign WBResultM_o  = MovM_i ? DATA_WIDTH'(imm8M_i) : alu_outM_i;

    assign pc_src_o    = jumpM_i | (BranchM_i & (alu_outM_i == '0));
    assign flush_o     = pc_src_o;
    assign pc_target_o = jumpM_i ? ADDR_WIDTH'(imm8M_i)
                                 : PCM_i + ADDR_WIDTH'(imm8M_i);

    logic [DATA_WIDTH-1:0] rdata_cap_q, rdata_cap_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [REG_WIDTH-1:0]  write_reg_q, write_reg_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic [DATA_WIDTH-1:0] result_a_q, result_a_d;

    always_comb begin
        rdata_cap_d  = rdata_cap_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        write_reg_d  = write_reg_q;
        read_data_d  = read_data_q;
        result_a_d   = result_a_q;
        if (fsm_capture) begin
            rdata_cap_d = fsm_timeout ? '0 : dmem_rdata_i;
        end
        // A stalled edge inserts a bubble into WB; the held instruction retires later.
        if (stall_mem_o) begin
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else begin
            reg_write_d  = RegWriteM_i;
            mem_to_reg_d = MemToRegM_i;
            write_reg_d  = WriteRegM_i;
            read_data_d  = (fsm_state == ST_RESP) ? rdata_cap_q : '0;
            result_a_d   = WBResultM_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_cap_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            write_reg_q  <= '0;
            read_data_q  <= '0;
            result_a_q   <= '0;
        end else begin
            rdata_cap_q  <= rdata_cap_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            write_reg_q  <= write_reg_d;
            read_data_q  <= read_data_d;
            result_a_q   <= result_a_d;
        end
    end

    assign RegWriteW_o = reg_write_q;
    assign MemToRegW_o = mem_to_reg_q;
    assign WriteRegW_o = write_reg_q;
    assign ReadDataW_o = read_data_q;
    assign ResultAW_o  = result_a_q;

endmodule
